// File: rtl/elastic_bufx_chain.sv
// elastic_bufx_chain: DEPTH-stage registered elastic buffer chain, valid/ready on both sides.
// Latency: a word accepted at edge N is on out_valid/out_data after edge N+DEPTH-1 when unstalled; 1 word/cycle.
// Backpressure: words pack toward the output; in_ready (combinational) drops only with all stages full.
// Optional feature: define ELASTIC_BUFX_FLUSH_EN to add a synchronous flush input.
module elastic_bufx_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count
`ifdef ELASTIC_BUFX_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  // Stage state: index 0 sits at the input, index DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [CNT_W-1:0]            count_q, count_d;

  // Per-stage advance enables and the word each stage would load when advancing.
  logic [DEPTH-1:0]            adv;
  logic                        adv_acc;
  logic [DEPTH-1:0]            v_src;
  logic [DEPTH-1:0][WIDTH-1:0] d_src;
  logic                        push;
  logic                        pop;

  // Stage i's source is stage i-1; stage 0 is fed straight from the upstream port.
  generate
    if (DEPTH > 1) begin : g_src_chain
      assign v_src = {v_q[DEPTH-2:0], in_valid};
      assign d_src = {d_q[DEPTH-2:0], in_data};
    end else begin : g_src_single
      assign v_src = in_valid;
      assign d_src = in_data;
    end
  endgenerate

  // A stage may advance when it, or any stage between it and the sink, is empty, or the sink takes a word.
  always_comb begin
    adv     = '0;
    adv_acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_acc = adv_acc | ~v_q[i];
      adv[i]  = adv_acc;
    end
  end

  // Handshake outputs; the ready path intentionally ripples through the whole chain.
`ifdef ELASTIC_BUFX_FLUSH_EN
  assign in_ready  = adv[0] & ~flush;
`else
  assign in_ready  = adv[0];
`endif
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = v_q[DEPTH-1] & out_ready;

  // Next state: advancing stages copy their source valid; data only moves with a valid word.
  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      if (adv[i]) begin
        v_d[i] = v_src[i];
        if (v_src[i]) begin
          d_d[i] = d_src[i];
        end
      end
    end
`ifdef ELASTIC_BUFX_FLUSH_EN
    // Flush wins over any load: every slot goes empty, stale data stays put.
    if (flush) begin
      v_d     = '0;
      d_d     = d_q;
      count_d = '0;
    end
`endif
  end

  // State registers; reset empties the chain and zeroes stage data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

endmodule
